// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisors, parity encodings and the transmit state type.
// The receiver side reuses the same encodings, so TX can be looped straight into RX.
package uart_pkg;

    localparam int unsigned CLK_FREQ_DEFAULT = 32'd50_000_000;

    // Rounded clock cycles per bit for a given clock and baud rate.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return (clk_freq + baud / 32'd2) / baud;
    endfunction

    localparam int unsigned DIV_2400  = baud_div(CLK_FREQ_DEFAULT, 32'd2400);
    localparam int unsigned DIV_4800  = baud_div(CLK_FREQ_DEFAULT, 32'd4800);
    localparam int unsigned DIV_9600  = baud_div(CLK_FREQ_DEFAULT, 32'd9600);
    localparam int unsigned DIV_19200 = baud_div(CLK_FREQ_DEFAULT, 32'd19200);

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Parity slot value; the "none" modes transmit a constant 1.
    function automatic logic frame_parity(input logic [7:0] data, input logic [1:0] mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~(^data);
            PAR_NONE: p = 1'b1;
            default:  p = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_frame_sender_if.sv
// Request/line bundle between a byte source and the UART frame sender.
interface uart_tx_frame_sender_if;
    logic [1:0] baud_rate;
    logic [1:0] parity_type;
    logic [7:0] din;
    logic       send;
    logic       dout;
    logic       busy;
    logic       done;
    logic       parity_bit;

    modport master (output baud_rate, parity_type, din, send,
                    input  dout, busy, done, parity_bit);
    modport slave  (input  baud_rate, parity_type, din, send,
                    output dout, busy, done, parity_bit);
endinterface

// File: rtl/uart_baud_gen.sv
// Loadable bit-period down-counter: bit_end is high in the last cycle of every DIV-cycle period.
// A load pulse restarts the period from the new divisor; shared with the receiver.
module uart_baud_gen #(
    parameter int DIV_W = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end
);
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] cnt_r;

    // Count down to zero, then reload from the latched divisor.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r <= '0;
            cnt_r <= '0;
        end else if (load) begin
            div_r <= div;
            cnt_r <= div - DIV_W'(1);
        end else if (cnt_r == '0) begin
            cnt_r <= div_r - DIV_W'(1);
        end else begin
            cnt_r <= cnt_r - DIV_W'(1);
        end
    end

    assign bit_end = (cnt_r == '0);
endmodule

// File: rtl/uart_tx_frame_sender.sv
// UART transmitter: one byte per accepted request as start, 8 data LSB first, parity slot, stop.
// Acceptance is allowed in the final stop cycle so a held send streams frames with no idle gap.
module uart_tx_frame_sender
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 32'd50_000_000,
    parameter int          DIV_W    = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_tx_frame_sender_if.slave  bus
);
    localparam logic [DIV_W-1:0] DIV_2400_C  = DIV_W'(baud_div(CLK_FREQ, 32'd2400));
    localparam logic [DIV_W-1:0] DIV_4800_C  = DIV_W'(baud_div(CLK_FREQ, 32'd4800));
    localparam logic [DIV_W-1:0] DIV_9600_C  = DIV_W'(baud_div(CLK_FREQ, 32'd9600));
    localparam logic [DIV_W-1:0] DIV_19200_C = DIV_W'(baud_div(CLK_FREQ, 32'd19200));

    tx_state_e        state_r;
    logic [7:0]       shift_r;
    logic [2:0]       idx_r;
    logic             dout_r;
    logic             parity_r;
    logic             bit_end_s;
    logic             last_stop_s;
    logic             busy_s;
    logic             accept_s;
    logic [DIV_W-1:0] div_sel_s;

    assign last_stop_s = (state_r == TX_STOP) && bit_end_s;
    assign busy_s      = (state_r != TX_IDLE) && !last_stop_s;
    assign accept_s    = bus.send && !busy_s;

    // Divisor for the requested baud rate; only used on the accepting edge.
    always_comb begin
        div_sel_s = DIV_2400_C;
        case (bus.baud_rate)
            2'b00:   div_sel_s = DIV_2400_C;
            2'b01:   div_sel_s = DIV_4800_C;
            2'b10:   div_sel_s = DIV_9600_C;
            2'b11:   div_sel_s = DIV_19200_C;
            default: div_sel_s = DIV_2400_C;
        endcase
    end

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (accept_s),
        .div     (div_sel_s),
        .bit_end (bit_end_s)
    );

    // Frame sequencer; the line is always driven from dout_r.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= TX_IDLE;
            shift_r  <= 8'h00;
            idx_r    <= 3'd0;
            dout_r   <= 1'b1;
            parity_r <= 1'b0;
        end else if (accept_s) begin
            state_r  <= TX_START;
            shift_r  <= bus.din;
            idx_r    <= 3'd0;
            dout_r   <= 1'b0;
            parity_r <= frame_parity(bus.din, bus.parity_type);
        end else begin
            case (state_r)
                TX_IDLE: begin
                    dout_r <= 1'b1;
                end
                TX_START: begin
                    if (bit_end_s) begin
                        dout_r  <= shift_r[0];
                        shift_r <= {1'b0, shift_r[7:1]};
                        state_r <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (bit_end_s) begin
                        if (idx_r == 3'd7) begin
                            dout_r  <= parity_r;
                            state_r <= TX_PARITY;
                        end else begin
                            dout_r  <= shift_r[0];
                            shift_r <= {1'b0, shift_r[7:1]};
                            idx_r   <= idx_r + 3'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (bit_end_s) begin
                        dout_r  <= 1'b1;
                        state_r <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (bit_end_s) begin
                        dout_r  <= 1'b1;
                        state_r <= TX_IDLE;
                    end
                end
                default: begin
                    dout_r  <= 1'b1;
                    state_r <= TX_IDLE;
                end
            endcase
        end
    end

    assign bus.dout       = dout_r;
    assign bus.busy       = busy_s;
    assign bus.done       = last_stop_s;
    assign bus.parity_bit = parity_r;
endmodule

// File: tb/tb_uart_tx_frame_sender.sv
// Self-checking bench for uart_tx_frame_sender, run with a scaled-down clock so frames stay short.
// Expected frames come from a bit-list model of the UART frame format.
module tb_uart_tx_frame_sender;
    localparam int unsigned CLK_FREQ = 500_000;

    logic clk = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    uart_tx_frame_sender_if bus ();

    uart_tx_frame_sender #(.CLK_FREQ(CLK_FREQ), .DIV_W(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Cycles per bit: nearest integer to CLK_FREQ / baud.
    function automatic int model_div(input logic [1:0] sel);
        int baud;
        baud = 2400 << sel;
        return (int'(CLK_FREQ) + baud / 2) / baud;
    endfunction

    function automatic logic model_parity(input logic [7:0] d, input logic [1:0] mode);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (mode == 2'b10)      return (ones % 2) == 1;
        else if (mode == 2'b01) return (ones % 2) == 0;
        else                    return 1'b1;
    endfunction

    // Present a request one edge ahead; returns just after the accepting edge.
    task automatic start_frame(input logic [7:0] data, input logic [1:0] baud,
                               input logic [1:0] mode, input bit hold);
        @(posedge clk); #1;
        bus.din = data; bus.baud_rate = baud; bus.parity_type = mode; bus.send = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.send = 1'b0;
    endtask

    // Watch one whole frame from the cycle after acceptance and compare it against the model.
    task automatic monitor_frame(input string name, input logic [7:0] data, input logic [1:0] baud,
                                 input logic [1:0] mode, input bit repulse, input bit chain,
                                 input logic [7:0] next_din, input bit release_at0);
        int   div, len, bad_line, bad_busy, first_t, busy_t, done_cnt, done_at;
        logic exp_bits [11];
        logic exp_par, act, expv, par_seen;
        logic [7:0] rec;
        div = model_div(baud);
        len = 11 * div;
        exp_par = model_parity(data, mode);
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[1 + i] = data[i];
        exp_bits[9]  = exp_par;
        exp_bits[10] = 1'b1;
        bad_line = 0; bad_busy = 0; first_t = -1; busy_t = -1; done_cnt = 0; done_at = -1;
        rec = 8'h00; act = 1'b0; expv = 1'b0; par_seen = 1'b0;
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            if (t == 0) begin
                par_seen = bus.parity_bit;
                if (release_at0) bus.send = 1'b0;
            end
            if (chain && t == 1) bus.din = next_din;
            if (!chain && t == 2 * div) begin
                bus.din = 8'($urandom); bus.baud_rate = 2'($urandom); bus.parity_type = 2'($urandom);
            end
            if (repulse && t == 5 * div)     bus.send = 1'b1;
            if (repulse && t == 5 * div + 3) bus.send = 1'b0;
            if (bus.dout !== exp_bits[t / div]) begin
                if (bad_line == 0) begin first_t = t; act = bus.dout; expv = exp_bits[t / div]; end
                bad_line++;
            end
            if (bus.busy !== (t != len - 1)) begin
                if (bad_busy == 0) busy_t = t;
                bad_busy++;
            end
            if (bus.done === 1'b1) begin done_cnt++; done_at = t; end
            if (t % div == div / 2 && t / div >= 1 && t / div <= 8) rec[t / div - 1] = bus.dout;
        end
        tests_run++;
        if (bad_line != 0) begin
            tests_failed++;
            $display("FAIL %s line: cycle %0d got %b expected %b (%0d bad cycles)", name, first_t, act, expv, bad_line);
        end
        tests_run++;
        if (bad_busy != 0) begin
            tests_failed++;
            $display("FAIL %s busy: first wrong at cycle %0d, %0d bad cycles", name, busy_t, bad_busy);
        end
        tests_run++;
        if (done_cnt != 1 || done_at != len - 1) begin
            tests_failed++;
            $display("FAIL %s done: %0d pulses, last at %0d, expected 1 pulse at %0d", name, done_cnt, done_at, len - 1);
        end
        tests_run++;
        if (par_seen !== exp_par) begin
            tests_failed++;
            $display("FAIL %s parity_bit: got %b expected %b", name, par_seen, exp_par);
        end
        tests_run++;
        if (rec !== data) begin
            tests_failed++;
            $display("FAIL %s recovered byte: got %h expected %h", name, rec, data);
        end
    endtask

    // Check the line stays idle for a number of cycles.
    task automatic check_idle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.dout !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL %s idle: %0d cycles not idle, expected 0", name, bad);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.send = 1'b0; bus.din = 8'h00; bus.baud_rate = 2'b00; bus.parity_type = 2'b00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({bus.dout, bus.busy, bus.done, bus.parity_bit} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset state: dout/busy/done/parity got %b%b%b%b expected 1000",
                     bus.dout, bus.busy, bus.done, bus.parity_bit);
        end
        check_idle("reset", 2000);
    endtask

    task automatic test_even_19200();
        start_frame(8'hA5, 2'b11, 2'b10, 1'b0);
        monitor_frame("even_19200", 8'hA5, 2'b11, 2'b10, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_odd_2400();
        start_frame(8'h01, 2'b00, 2'b01, 1'b0);
        monitor_frame("odd_2400", 8'h01, 2'b00, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_none_repulse();
        start_frame(8'h00, 2'b10, 2'b00, 1'b0);
        monitor_frame("none_9600", 8'h00, 2'b10, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0);
        check_idle("none_9600 after", 3 * model_div(2'b10));
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic [1:0] b, m;
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom); b = 2'($urandom); m = 2'($urandom);
            start_frame(d, b, m, 1'b0);
            monitor_frame($sformatf("random%0d", i), d, b, m, 1'($urandom_range(0, 1)), 1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] m;
        m = 2'($urandom);
        start_frame(8'h55, 2'b11, m, 1'b1);
        monitor_frame("b2b first", 8'h55, 2'b11, m, 1'b0, 1'b1, 8'hAA, 1'b0);
        monitor_frame("b2b second", 8'hAA, 2'b11, m, 1'b0, 1'b0, 8'h00, 1'b1);
        check_idle("b2b after", 40);
    endtask

    task automatic test_reset_mid();
        int div, done_seen;
        div = model_div(2'b11);
        done_seen = 0;
        start_frame(8'($urandom), 2'b11, 2'b10, 1'b0);
        for (int t = 0; t <= 4 * div + div / 2; t++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.dout !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: dout/busy/done got %b%b%b expected 100", bus.dout, bus.busy, bus.done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 12 * div; t++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.dout !== 1'b1) done_seen++;
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("FAIL reset_mid abort: %0d cycles with done or line low, expected 0", done_seen);
        end
        start_frame(8'h3C, 2'b11, 2'b01, 1'b0);
        monitor_frame("after_reset", 8'h3C, 2'b11, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_even_19200();
        test_odd_2400();
        test_none_repulse();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/uart_tx_frame_sender.md
Name: uart_tx_frame_sender

Overview:
- UART transmitter; the transmit end of the link served by the UART receiver top module.
- Serialises one byte per request into an 11-bit frame on the same 50 MHz clock: start, 8 data bits LSB first, parity slot, stop.
- Uses the receiver's baud_rate and parity_type encodings, so the TX output can be looped straight into the RX din in system benches.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz; the divisor constants are derived from it.
- DIV_W, 15, width of the bit-period counter; must hold the largest divisor, 20833.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- baud_rate  input  2  00=2400, 01=4800, 10=9600, 11=19200 baud; sampled only when send is accepted.
- parity_type  input  2  01=odd, 10=even, 00/11=none (parity slot sent as 1); sampled only when send is accepted.
- din  input  8  byte to transmit; sampled only when send is accepted.
- send  input  1  transmit request, level or pulse.
- dout  output  1  serial line; idle high.
- busy  output  1  high while a frame is in flight.
- done  output  1  one-cycle pulse in the last cycle of the stop bit.
- parity_bit  output  1  parity value of the current or last frame.

Behaviour:
- Reset, synchronous and active-high: state=IDLE, dout=1, busy=0, done=0, parity_bit=0, counters=0.
- Reset asserted mid-frame aborts the frame: dout=1 on the next edge and no done pulse is issued.
- Divisors, in cycles per bit (round(CLK_FREQ/baud)): 20833, 10417, 5208, 2604.
- Acceptance: send=1 while busy=0 at edge k latches din, the divisor and the parity mode.
  - The parity bit is computed from the latched byte at acceptance:
    - even: XOR of all data bits;
    - odd: inverted XOR;
    - none: 1.
  - parity_bit updates at edge k.
- Latency: dout=0 (start bit) and busy=1 from edge k; total frame length is exactly 11*DIV cycles.
- State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - Each bit is held for exactly DIV cycles; the counter runs 0..DIV-1 and advances the state on DIV-1.
  - DATA uses a 3-bit index 0..7 and sends din[index], LSB first; it leaves DATA when index=7 and the counter hits DIV-1.
- STOP: dout=1. In the final STOP cycle, done=1 and busy=0 combinationally, so the next request can be accepted at that edge.
- Back-to-back: send held high gives a new start bit immediately after the stop bit, with no idle gap.
- send while busy=1 (other than the final STOP cycle) is ignored; it is not queued.
- Changes to din, baud_rate or parity_type mid-frame have no effect on the current frame.
- dout is driven from a register, so it is glitch-free.

Decomposition:
- Package uart_pkg holds:
  - the divisor constants DIV_2400/4800/9600/19200, computed from CLK_FREQ;
  - the parity encodings PAR_NONE/PAR_ODD/PAR_EVEN;
  - the tx state enum.
- One sub-module, uart_baud_gen: loadable down-counter that emits a bit_end strobe every DIV cycles.
  - Restarts on a load pulse from the FSM.
  - Intended for reuse by the receiver side.

Test Plan:
- Idle check: reset=1 for 3 cycles, then 0 -> dout=1, busy=0, done=0; nothing changes over 10000 cycles with send=0.
- 19200 baud, even parity, din=8'hA5, one-cycle send:
  - line sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 2604 cycles (52080 ns);
  - parity_bit=0; done pulses exactly once at cycle 28644 after acceptance.
- 2400 baud, odd parity, din=8'h01:
  - parity slot = 0, each bit lasts 20833 cycles, total frame 229163 cycles.
- No parity, 9600 baud, din=8'h00:
  - parity slot = 1; send re-pulsed mid-frame is ignored and only one done pulse appears.
- Back-to-back: send held high with din=8'h55 then 8'hAA at 19200 baud:
  - the second start bit falls on the cycle right after the first stop bit ends;
  - looped into the receiver, it recovers 8'h55 and 8'hAA.
- Reset mid-frame: assert reset during DATA bit 3 -> dout=1 and busy=0 on the next edge, no done pulse; a new send afterwards produces a clean full frame.
